seg_disp_driver: RTL and testbench

Upstream feeder for the 7-segment decoder. Accepts a signed binary value on a start strobe and converts it to BCD with a sequential double-dabble engine, one shift per cycle. It applies leading-zero blanking and minus-sign placement, then time-multiplexes the digits. Each scan slot presents one 4-bit digit code (0-9, 4'b1010 = minus, 4'b1111 = blank) to the decoder, plus an active-low digit-select strobe.

---
 rtl/seg_disp_driver_if.sv | 23 ++
 rtl/seg_disp_driver.sv | 139 +++++++++++++
 tb/tb_seg_disp_driver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seg_disp_driver_if.sv
// Handshake and display bus between a value producer, the BCD/scan driver
// and the downstream 7-segment decoder.
interface seg_disp_driver_if #(
    parameter int WIDTH = 10,
    parameter int NDIG  = 4
);
    logic signed [WIDTH-1:0] value;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [3:0]              digit_code;
    logic [NDIG-1:0]         an;

    modport master (
        output value, start,
        input  busy, done, digit_code, an
    );

    modport slave (
        input  value, start,
        output busy, done, digit_code, an
    );
endinterface

// File: rtl/seg_disp_driver.sv
// Signed binary to BCD (sequential double-dabble) with leading-zero blanking,
// minus-sign placement and time-multiplexed digit scan for a 7-segment decoder.
module seg_disp_driver #(
    parameter int WIDTH    = 10,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    seg_disp_driver_if.slave bus
);
    localparam int BW     = 4 * NDIG;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SEL_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [3:0] CODE_MINUS = 4'b1010;
    localparam logic [3:0] CODE_BLANK = 4'b1111;

    typedef enum logic {IDLE, CONV} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]      shift_cnt;
    logic                  neg;
    logic [BW+WIDTH-1:0]   work, work_next;
    logic [BW-1:0]         bcd_adj, bcd_final;
    logic [WIDTH-1:0]      raw, mag;
    logic                  accept, last, neg_eff;
    int                    msd;
    logic                  done_q;
    logic [3:0]            disp      [NDIG];
    logic [3:0]            disp_next [NDIG];

    logic [SCAN_W-1:0]     scan_cnt;
    logic [SEL_W-1:0]      sel, sel_next;
    logic                  slot_end;
    logic [NDIG-1:0]       an_q;
    logic [3:0]            code_q;

    assign raw    = bus.value;
    assign mag    = raw[WIDTH-1] ? (~raw + 1'b1) : raw;
    assign accept = bus.start && (state == IDLE);
    assign last   = (state == CONV) && (shift_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CONV;
            CONV:    if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, mag}.
    always_comb begin
        bcd_adj = work[BW+WIDTH-1:WIDTH];
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_adj[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        work_next = {bcd_adj, work[WIDTH-1:0]} << 1;
    end

    // Formatting is taken from the post-shift value so the display loads on
    // the same edge as the final shift.
    always_comb begin
        bcd_final = work_next[BW+WIDTH-1:WIDTH];
        neg_eff   = neg && (bcd_final != '0);
        msd       = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_final[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < NDIG; i++) begin
            if (i <= msd)                     disp_next[i] = bcd_final[4*i +: 4];
            else if (neg_eff && i == msd + 1) disp_next[i] = CODE_MINUS;
            else                              disp_next[i] = CODE_BLANK;
        end
    end

    // NOTE: the display registers are a handful of flops, not a RAM, so they
    // are reset explicitly to blank; a reset mid-conversion leaves no stale digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q    <= 1'b0;
            neg       <= 1'b0;
            work      <= '0;
            shift_cnt <= '0;
            for (int i = 0; i < NDIG; i++) disp[i] <= CODE_BLANK;
        end else begin
            done_q <= last;
            if (accept) begin
                neg       <= raw[WIDTH-1];
                work      <= {{BW{1'b0}}, mag};
                shift_cnt <= '0;
            end else if (state == CONV) begin
                work      <= work_next;
                shift_cnt <= shift_cnt + 1'b1;
                if (last) begin
                    for (int i = 0; i < NDIG; i++) disp[i] <= disp_next[i];
                end
            end
        end
    end

    assign slot_end = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        sel_next = sel;
        if (slot_end) sel_next = (sel == SEL_W'(NDIG - 1)) ? '0 : sel + 1'b1;
    end

    // an and digit_code share sel_next, so they always switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            sel      <= '0;
            an_q     <= ~NDIG'(1);
            code_q   <= CODE_BLANK;
        end else begin
            scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
            sel      <= sel_next;
            an_q     <= ~(NDIG'(1) << sel_next);
            code_q   <= disp[sel_next];
        end
    end

    assign bus.busy       = (state == CONV);
    assign bus.done       = done_q;
    assign bus.an         = an_q;
    assign bus.digit_code = code_q;
endmodule

// File: tb/tb_seg_disp_driver.sv
// Self-checking bench for seg_disp_driver: directed and random conversions
// compared against a decimal-arithmetic reference of the expected display.
module tb_seg_disp_driver;
    localparam int WIDTH    = 10;
    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    seg_disp_driver_if #(.WIDTH(WIDTH), .NDIG(NDIG)) bus ();

    seg_disp_driver #(.WIDTH(WIDTH), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected digit codes from plain decimal arithmetic, digit 0 in the low nibble.
    function automatic logic [4*NDIG-1:0] model(input int v);
        logic [4*NDIG-1:0] r;
        int m;
        int nd;
        r  = {NDIG{4'hF}};
        m  = (v < 0) ? -v : v;
        nd = 0;
        do begin
            r[4*nd +: 4] = 4'(m % 10);
            m  = m / 10;
            nd++;
        end while (m > 0);
        if (v < 0) r[4*nd +: 4] = 4'hA;
        return r;
    endfunction

    task automatic check_display(input logic [4*NDIG-1:0] exp, input string tag);
        for (int d = 0; d < NDIG; d++) begin
            logic [NDIG-1:0] want;
            int waited;
            want   = ~(NDIG'(1) << d);
            waited = 0;
            while (bus.an !== want && waited < NDIG * SCAN_DIV + 2) begin
                @(negedge clk);
                waited++;
            end
            check($sformatf("%s_an%0d", tag, d), 32'(bus.an), 32'(want));
            check($sformatf("%s_code%0d", tag, d), 32'(bus.digit_code), 32'(exp[4*d +: 4]));
        end
    endtask

    // Start pulse in cycle N; busy in N+1..N+WIDTH, done only in N+WIDTH+1.
    // A non-zero restart_at drives a second start in that busy cycle.
    task automatic run_conv(input int v, input int restart_at, input int v2, input string tag);
        @(negedge clk);
        bus.value = WIDTH'(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            check($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
            check($sformatf("%s_nodone%0d", tag, i), 32'(bus.done), 32'd0);
            if (i == restart_at) begin
                bus.value = WIDTH'(v2);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_display(model(v), tag);
    endtask

    initial begin
        int done_cnt;
        int v;
        reset     = 1'b1;
        bus.value = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_an", 32'(bus.an), 32'(4'b1110));
        check("rst_code", 32'(bus.digit_code), 32'hF);

        for (int t = 0; t < 4 * SCAN_DIV; t++) begin
            logic [NDIG-1:0] exp_an;
            exp_an = ~(NDIG'(1) << ((t / SCAN_DIV) % NDIG));
            check($sformatf("idle_an_t%0d", t), 32'(bus.an), 32'(exp_an));
            check($sformatf("idle_code_t%0d", t), 32'(bus.digit_code), 32'hF);
            check($sformatf("idle_busy_t%0d", t), 32'(bus.busy | bus.done), 32'd0);
            @(negedge clk);
        end

        run_conv(123, 0, 0, "v123");
        run_conv(-45, 0, 0, "vm45");
        run_conv(0, 0, 0, "v0");
        run_conv(-512, 0, 0, "vm512");
        run_conv(511, 0, 0, "v511");

        for (int n = 0; n < 10; n++) begin
            v = int'($urandom_range(1023)) - 512;
            run_conv(v, 0, 0, $sformatf("rnd%0d", n));
        end

        // Second start during conversion must be ignored.
        run_conv(7, 3, 9, "ign");
        done_cnt = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("ign_no_extra_done", 32'(done_cnt), 32'd0);
        check_display(model(7), "ign_hold");

        // Reset in the middle of a conversion aborts it and blanks the display.
        @(negedge clk);
        bus.value = WIDTH'(88);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        done_cnt = 0;
        repeat (WIDTH + 4) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check_display({NDIG{4'hF}}, "abort_blank");
        run_conv(6, 0, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
